// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution window: default widths, row-phase
// encoding and the signed saturation helper used by the MAC.
package conv_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int W_W_DEF    = 8;
  localparam int ACC_W_DEF  = 21;

  // Working width of the saturation helper; any MAC sum must fit inside it.
  localparam int SAT_W = 64;

  typedef enum logic [1:0] {
    PH_TOP = 2'd0,
    PH_MID = 2'd1,
    PH_BOT = 2'd2,
    PH_BAD = 2'd3
  } phase_e;

  function automatic logic signed [SAT_W-1:0] sat_signed(
    input logic signed [SAT_W-1:0] value,
    input int                      acc_w
  );
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (value > max_v) begin
      sat_signed = max_v;
    end else if (value < min_v) begin
      sat_signed = min_v;
    end else begin
      sat_signed = value;
    end
  endfunction

endpackage

// File: rtl/conv3x3_mac.sv
// Pipelined 9-tap signed dot product: products registered, then row sums
// registered; the final add and saturation feed the caller's output register.
module conv3x3_mac
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int W_W    = W_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue,
  input  logic [9*DATA_W-1:0]   win,
  input  logic [9*W_W-1:0]      weights,
  output logic [ACC_W-1:0]      res,
  output logic                  res_vld
);

  localparam int PROD_W = DATA_W + W_W + 1;
  localparam int ROW_W  = PROD_W + 2;
  localparam int SUM_W  = PROD_W + 4;

  logic signed [PROD_W-1:0] prod_c [9];
  logic signed [PROD_W-1:0] prod   [9];
  logic signed [ROW_W-1:0]  row_c  [3];
  logic signed [ROW_W-1:0]  row    [3];
  logic signed [SUM_W-1:0]  sum;
  logic signed [SAT_W-1:0]  sat_full;
  logic                     v1;
  logic                     v2;

  // Pixels are unsigned: zero-extend them, sign-extend the weights.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      logic signed [PROD_W-1:0] px_e;
      logic signed [PROD_W-1:0] wt_e;
      px_e = {{(PROD_W-DATA_W){1'b0}}, win[k*DATA_W +: DATA_W]};
      wt_e = {{(PROD_W-W_W){weights[k*W_W+W_W-1]}}, weights[k*W_W +: W_W]};
      prod_c[k] = px_e * wt_e;
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      row_c[r] = {{2{prod[3*r][PROD_W-1]}},   prod[3*r]}
               + {{2{prod[3*r+1][PROD_W-1]}}, prod[3*r+1]}
               + {{2{prod[3*r+2][PROD_W-1]}}, prod[3*r+2]};
    end
  end

  always_comb begin
    sum = {{2{row[0][ROW_W-1]}}, row[0]}
        + {{2{row[1][ROW_W-1]}}, row[1]}
        + {{2{row[2][ROW_W-1]}}, row[2]};
    sat_full = sat_signed({{(SAT_W-SUM_W){sum[SUM_W-1]}}, sum}, ACC_W);
    res      = sat_full[ACC_W-1:0];
    res_vld  = v2;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= issue;
      v2 <= v1;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      for (int k = 0; k < 9; k++) begin
        prod[k] <= prod_c[k];
      end
    end
    if (v1) begin
      for (int r = 0; r < 3; r++) begin
        row[r] <= row_c[r];
      end
    end
  end

endmodule

// File: rtl/conv3x3_window.sv
// Assembles phase-tagged BRAM pixels into 3-pixel columns and a sliding 3x3
// window, convolves each full window and holds the result on a valid/ready port.
//
// exp_ph | meaning
// PH_TOP | waiting for the top pixel of a new column
// PH_MID | top pixel held, waiting for the middle pixel
// PH_BOT | top and middle held, waiting for the bottom pixel
module conv3x3_window
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int W_W    = W_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   pix_in,
  input  logic                pix_vld,
  input  logic [1:0]          c,
  input  logic                pad_mask,
  input  logic                col_start,
  input  logic [9*W_W-1:0]    weights,
  output logic [ACC_W-1:0]    out_data,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic                err_seq,
  output logic                err_ovf
);

  phase_e              exp_ph;
  logic [DATA_W-1:0]   col_top;
  logic [DATA_W-1:0]   col_mid;
  logic                cs_flag;
  logic [9*DATA_W-1:0] win;
  logic [1:0]          fill;
  logic                issue;

  logic [DATA_W-1:0]   pix_w;
  logic                acc_top;
  logic                acc_mid;
  logic                acc_bot;
  logic                seq_bad;
  logic [1:0]          fill_next;

  logic [ACC_W-1:0]    res;
  logic                res_vld;

  always_comb begin
    pix_w     = pad_mask ? '0 : pix_in;
    acc_top   = pix_vld && (c == PH_TOP);
    acc_mid   = pix_vld && (c == PH_MID) && (exp_ph == PH_MID);
    acc_bot   = pix_vld && (c == PH_BOT) && (exp_ph == PH_BOT);
    // A top pixel always restarts the column, but flags an abandoned partial one.
    seq_bad   = (pix_vld && !acc_top && !acc_mid && !acc_bot)
             || (acc_top && (exp_ph != PH_TOP));
    if (cs_flag) begin
      fill_next = 2'd1;
    end else if (fill == 2'd3) begin
      fill_next = 2'd3;
    end else begin
      fill_next = fill + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      exp_ph  <= PH_TOP;
      col_top <= '0;
      col_mid <= '0;
      cs_flag <= 1'b0;
      win     <= '0;
      fill    <= 2'd0;
      issue   <= 1'b0;
      err_seq <= 1'b0;
    end else begin
      issue <= 1'b0;
      if (seq_bad) begin
        err_seq <= 1'b1;
      end
      if (acc_top) begin
        col_top <= pix_w;
        cs_flag <= col_start;
        exp_ph  <= PH_MID;
      end else if (acc_mid) begin
        col_mid <= pix_w;
        exp_ph  <= PH_BOT;
      end else if (acc_bot) begin
        exp_ph <= PH_TOP;
        for (int r = 0; r < 3; r++) begin
          win[(3*r)*DATA_W   +: DATA_W] <= win[(3*r+1)*DATA_W +: DATA_W];
          win[(3*r+1)*DATA_W +: DATA_W] <= win[(3*r+2)*DATA_W +: DATA_W];
        end
        win[2*DATA_W +: DATA_W] <= col_top;
        win[5*DATA_W +: DATA_W] <= col_mid;
        win[8*DATA_W +: DATA_W] <= pix_w;
        fill  <= fill_next;
        issue <= (fill_next == 2'd3);
      end else if (pix_vld) begin
        exp_ph <= PH_TOP;
      end
    end
  end

  conv3x3_mac #(
    .DATA_W (DATA_W),
    .W_W    (W_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .issue   (issue),
    .win     (win),
    .weights (weights),
    .res     (res),
    .res_vld (res_vld)
  );

  // Single-entry output slot: a result that finds it occupied is lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      err_ovf  <= 1'b0;
    end else if (res_vld) begin
      if (!out_vld || out_rdy) begin
        out_vld  <= 1'b1;
        out_data <= res;
      end else begin
        err_ovf <= 1'b1;
      end
    end else if (out_vld && out_rdy) begin
      out_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv3x3_window.sv
// Directed bench for conv3x3_window: a column-queue model predicts every
// result, backed by literal expectations for the hand-worked vectors.
module tb_conv3x3_window;

  localparam int DW = 8;
  localparam int WW = 8;
  localparam int AW = 21;

  logic           clk = 1'b0;
  logic           rst;
  logic [DW-1:0]  pix_in;
  logic           pix_vld;
  logic [1:0]     c;
  logic           pad_mask;
  logic           col_start;
  logic [9*WW-1:0] weights;
  logic [9*WW-1:0] weights16;
  logic [AW-1:0]  out_data;
  logic           out_vld;
  logic           out_rdy;
  logic           err_seq;
  logic           err_ovf;
  logic [15:0]    out_data16;
  logic           out_vld16;
  logic           rdy16;
  logic           err_seq16;
  logic           err_ovf16;

  always #5 clk = ~clk;

  conv3x3_window #(.DATA_W(DW), .W_W(WW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_vld(pix_vld), .c(c),
    .pad_mask(pad_mask), .col_start(col_start), .weights(weights),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .err_seq(err_seq), .err_ovf(err_ovf)
  );

  conv3x3_window #(.DATA_W(DW), .W_W(WW), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_vld(pix_vld), .c(c),
    .pad_mask(pad_mask), .col_start(col_start), .weights(weights16),
    .out_data(out_data16), .out_vld(out_vld16), .out_rdy(rdy16),
    .err_seq(err_seq16), .err_ovf(err_ovf16)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Model: completed columns of the current output row, oldest first.
  typedef struct {
    int due;
    int val;
  } res_t;

  int   cyc = 0;
  int   m_exp;
  int   m_top, m_mid;
  bit   m_cs;
  int   q_top[$];
  int   q_mid[$];
  int   q_bot[$];
  res_t pend[$];
  bit   m_vld;
  int   m_data;
  bit   m_eseq, m_eovf;

  function automatic int wgt(input int k);
    logic signed [WW-1:0] w;
    w = weights[k*WW +: WW];
    return int'(w);
  endfunction

  task automatic model_step();
    int pv;
    int s;
    cyc++;
    if (!rst) begin
      m_exp = 0; m_top = 0; m_mid = 0; m_cs = 1'b0;
      q_top.delete(); q_mid.delete(); q_bot.delete(); pend.delete();
      m_vld = 1'b0; m_data = 0; m_eseq = 1'b0; m_eovf = 1'b0;
      return;
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      if (!m_vld || out_rdy) begin
        m_vld  = 1'b1;
        m_data = pend[0].val;
      end else begin
        m_eovf = 1'b1;
      end
      void'(pend.pop_front());
    end else if (m_vld && out_rdy) begin
      m_vld = 1'b0;
    end
    if (pix_vld) begin
      pv = pad_mask ? 0 : int'(pix_in);
      if (c == 2'd0) begin
        if (m_exp != 0) m_eseq = 1'b1;
        m_top = pv; m_cs = col_start; m_exp = 1;
      end else if (c == 2'd1 && m_exp == 1) begin
        m_mid = pv; m_exp = 2;
      end else if (c == 2'd2 && m_exp == 2) begin
        m_exp = 0;
        if (m_cs) begin
          q_top.delete(); q_mid.delete(); q_bot.delete();
        end
        q_top.push_back(m_top); q_mid.push_back(m_mid); q_bot.push_back(pv);
        if (q_top.size() > 3) begin
          void'(q_top.pop_front()); void'(q_mid.pop_front()); void'(q_bot.pop_front());
        end
        if (q_top.size() == 3) begin
          s = 0;
          for (int j = 0; j < 3; j++) begin
            s += q_top[j] * wgt(j) + q_mid[j] * wgt(3 + j) + q_bot[j] * wgt(6 + j);
          end
          if (s > (1 << (AW-1)) - 1) s = (1 << (AW-1)) - 1;
          if (s < -(1 << (AW-1)))    s = -(1 << (AW-1));
          pend.push_back('{due: cyc + 3, val: s});
        end
      end else begin
        m_eseq = 1'b1;
        m_exp  = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_vld", longint'(out_vld), longint'(m_vld));
      if (m_vld) check("out_data", longint'($signed(out_data)), longint'(m_data));
      check("err_seq", longint'(err_seq), longint'(m_eseq));
      check("err_ovf", longint'(err_ovf), longint'(m_eovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  task automatic send(input int ph, input int px, input bit pad, input bit cs);
    c = 2'(ph); pix_in = 8'(px); pad_mask = pad; col_start = cs; pix_vld = 1'b1;
    tick();
    #1;
    pix_vld = 1'b0;
  endtask

  task automatic send_col(input int p0, input int p1, input int p2, input bit pad0, input bit cs);
    send(0, p0, pad0, cs);
    send(1, p1, 1'b0, 1'b0);
    send(2, p2, 1'b0, 1'b0);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      #1;
      if (out_vld) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int seen;
    rdy16   = 1'b1;
    out_rdy = 1'b1;
    weights   = {9{8'd1}};
    weights16 = {9{8'd1}};
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pix_vld = 1'($urandom); c = 2'($urandom); pix_in = 8'($urandom);
      pad_mask = 1'($urandom); col_start = 1'($urandom); out_rdy = 1'($urandom);
      tick();
      #1;
    end
    check("rst_out_vld", longint'(out_vld), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_err_seq", longint'(err_seq), 0);
    check("rst_err_ovf", longint'(err_ovf), 0);
    pix_vld = 1'b0; out_rdy = 1'b1; pad_mask = 1'b0; col_start = 1'b0;
    rst = 1'b1;
    chk_en = 1'b1;
    tick(); #1;

    for (int k = 0; k < 3; k++) send_col(3*k+1, 3*k+2, 3*k+3, 1'b0, k == 0);
    wait_out(n);
    check("first_latency", n, 3);
    check("first_sum", longint'($signed(out_data)), 45);

    send_col(10, 11, 12, 1'b0, 1'b0);
    wait_out(n);
    check("second_latency", n, 3);
    check("second_sum", longint'($signed(out_data)), 72);

    send_col(13, 14, 15, 1'b0, 1'b1);
    send_col(16, 17, 18, 1'b0, 1'b0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      if (out_vld) seen++;
    end
    check("restart_no_output", seen, 0);
    send_col(19, 20, 21, 1'b0, 1'b0);
    wait_out(n);
    check("restart_latency", n, 3);
    check("restart_sum", longint'($signed(out_data)), 153);

    for (int k = 0; k < 3; k++) send_col(5, 5, 5, 1'b1, k == 0);
    wait_out(n);
    check("pad_sum", longint'($signed(out_data)), 30);

    tick(); #1;
    out_rdy = 1'b0;
    send_col(5, 5, 5, 1'b0, 1'b0);
    wait_out(n);
    check("bp_first_latency", n, 3);
    send_col(5, 5, 5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
    end
    check("bp_held_vld", longint'(out_vld), 1);
    check("bp_held_data", longint'($signed(out_data)), 35);
    check("bp_err_ovf", longint'(err_ovf), 1);
    out_rdy = 1'b1;
    tick(); #1;
    check("bp_drained", longint'(out_vld), 0);

    send(0, 5, 1'b0, 1'b0);
    send(2, 5, 1'b0, 1'b0);
    check("seq_err", longint'(err_seq), 1);
    send_col(1, 2, 3, 1'b0, 1'b0);
    wait_out(n);
    check("seq_fill_kept_latency", n, 3);
    check("seq_fill_kept_sum", longint'($signed(out_data)), 36);

    weights   = {9{8'd127}};
    weights16 = {9{8'd127}};
    for (int k = 0; k < 3; k++) send_col(255, 255, 255, 1'b0, k == 0);
    wait_out(n);
    check("max_sum_21", longint'($signed(out_data)), 291465);
    check("max_vld_16", longint'(out_vld16), 1);
    check("sat_16", longint'($signed(out_data16)), 32767);

    for (int k = 0; k < 9; k++) weights[k*WW +: WW] = 8'(k - 4);
    send_col(10, 20, 30, 1'b0, 1'b0);
    wait_out(n);
    check("signed_weights_sum", longint'($signed(out_data)), -645);

    for (int i = 0; i < 5; i++) begin
      tick(); #1;
    end
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv3x3_window.md
# conv3x3_window

Downstream consumer of the padding address generator. It takes pixel read-data returned from the image BRAM, tagged with the same row phase `c` (0..2) that produced the address, and assembles 3-pixel columns into a sliding 3x3 window. Each full window goes through a pipelined signed dot product with a 3x3 kernel, and the result is presented on a single-entry valid/ready output register. It feeds the activation/pooling stage.

## Interface
- `DATA_W`, 8: unsigned pixel width
- `W_W`, 8: signed weight width
- `ACC_W`, 21: signed output width; the full sum is saturated to this width
- `clk` in 1: single system clock; all logic on rising edge
- `rst` in 1: **synchronous, active-low** reset
- `pix_in` in DATA_W: BRAM read data for the current sample
- `pix_vld` in 1: `pix_in`/`c`/`pad_mask`/`col_start` valid this cycle
- `c` in 2: row phase of sample (0 top, 1 middle, 2 bottom; 3 illegal)
- `pad_mask` in 1: sample lies in padded region; treated as pixel 0
- `col_start` in 1: sample begins the first column of a new output row
- `weights` in 9*W_W: kernel, entry k = row*3+col at bits [k*W_W +: W_W], row 0 top, col 0 oldest
- `out_data` out ACC_W: convolution result
- `out_vld` out 1: `out_data` valid
- `out_rdy` in 1: consumer accepts when `out_vld & out_rdy`
- `err_seq` out 1: sticky, phase sequence violation
- `err_ovf` out 1: sticky, result dropped due to backpressure

## Operation
- Phase tracker `exp_ph` ∈ {0,1,2}, reset 0. Sample accepted when `pix_vld`:
  - c=0: always starts a new column; any partial column is discarded (if `exp_ph`≠0, set `err_seq`). Write `col[0]`, exp_ph←1.
  - c==exp_ph (1 or 2): write `col[c]`, exp_ph←(c+1)%3.
  - else (wrong phase or c=3): discard partial column, exp_ph←0, set `err_seq`; sample ignored.
  - Written value = `pad_mask ? 0 : pix_in`.
- Column complete on an accepted c=2 sample: window shifts left (col0←col1, col1←col2, col2←{col[0],col[1],this sample}). Fill counter `fill` (0..3, saturating) increments; if `col_start` was set on this column's c=0 sample, fill←1 instead.
- When a completed column leaves `fill`=3, window issues to the MAC (`issue`=1 for one cycle).
- MAC: products pixel (zero-extended) × weight, signed width DATA_W+W_W+1; three row sums; final sum width DATA_W+W_W+5; saturate to signed ACC_W range.
- Output register: on result arrival, load if `!out_vld | out_rdy`; else drop the result, set `err_ovf`. Arrival in the same cycle as acceptance loads the new result (`out_vld` stays 1).
- `err_*` clear only on reset.

## Timing
- Reset (rst=0 at edge): window, col, fill=0, exp_ph=0, pipeline valids=0, `out_vld`=0, `out_data`=0, `err_seq`=`err_ovf`=0. Reset mid-operation discards all in-flight results.
- Completing c=2 sample at edge t: window updated at t, products registered at t+1, row sums at t+2, `out_vld`=1 with `out_data` after edge t+3. Latency 3 cycles from the completing sample.
- Pipeline never stalls; backpressure acts only at the output register.
- Peak throughput: one result per 3 accepted samples. Gaps in `pix_vld` are allowed anywhere.

## Structure
- Shared `conv_pkg`: DATA_W/W_W defaults, phase constants PH_TOP/PH_MID/PH_BOT, function `sat_signed(value, ACC_W)`.
- Sub-module `conv3x3_mac`: 3-stage pipelined 9-tap dot product with saturation. The top level holds the phase tracker, column/window registers, fill logic and output register.

## Test plan
- Reset: hold rst=0 for 2 cycles with random inputs → `out_vld`=0, `out_data`=0, both errors 0.
- Weights all 1, `col_start` on first sample, pixels 1..9 in c order 0,1,2 ×3 → exactly one result, `out_data`=45, 3 cycles after 9th sample.
- Continue with 4th column 10,11,12 → second result 72. Then `col_start` column → no output until 3 more columns.
- Weights all 1, pixels all 5, `pad_mask`=1 on the three c=0 samples → 30.
- `out_rdy`=0, feed two windows → first result held, second dropped, `err_ovf`=1. Raise `out_rdy` → first accepted, `out_vld`→0.
- Sequence c=0,c=2 → `err_seq`=1, fill unchanged. Separately, ACC_W=16, pixels 255, weights 127 → `out_data`=32767.
